// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, light codes and timer constant for the phase controller
package traffic_pkg;
  typedef enum logic [2:0] {MG = 3'd0, MY = 3'd1, AR_M = 3'd2, SG = 3'd3, SY = 3'd4, AR_S = 3'd5} state_t;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int TIMER_RELOAD = 1800;
  function automatic logic counted(input state_t s);
    return s inside {MY, AR_M, SY, AR_S};
  endfunction
endpackage

// File: rtl/phase_down_counter.sv
// phase_down_counter: 8-bit loadable down-counter timing yellow and all-red phases
// Ports: clk, rst_n (async active-low), load/load_val (reload), en (count enable),
//        value (current count), zero (value == 0). Saturates at 0.
module phase_down_counter #(
  parameter logic [7:0] RST_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       zero
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= RST_VAL;
    else if (load) value <= load_val;
    else if (en && value != 8'd0) value <= value - 8'd1;
  assign zero = value == 8'd0;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: main/side intersection phase sequencer with pedestrian walk
// Ports: tclk, rst_n (async active-low), t (green timer expiry), car_side, ped_req,
//        ct (timer reload), main_light/side_light ({red,yellow,green}), walk, state_o.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int YEL_CYC    = 6,
  parameter int ALLRED_CYC = 4
) (
  input  logic       tclk,
  input  logic       rst_n,
  input  logic       t,
  input  logic       car_side,
  input  logic       ped_req,
  output logic       ct,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state_o
);
  state_t state, next;
  logic min_done, min_done_n, ped_pend, ped_pend_n, walk_n, ct_n, enter_sg, load, zero;
  logic [7:0] load_val, cnt;
  phase_down_counter #(.RST_VAL(8'(ALLRED_CYC - 1))) u_cnt (
    .clk(tclk), .rst_n(rst_n), .load(load), .en(counted(state)),
    .load_val(load_val), .value(cnt), .zero(zero)
  );
  // t on the expiry edge counts as minimum reached, so MG can leave on that same edge
  always_comb begin
    next = state;
    case (state)
      MG:      if ((min_done || t) && (car_side || ped_pend)) next = MY;
      MY:      if (zero) next = AR_M;
      AR_M:    if (zero) next = SG;
      SG:      if (t) next = SY;
      SY:      if (zero) next = AR_S;
      AR_S:    if (zero) next = MG;
      default: next = AR_S;
    endcase
  end
  always_comb begin
    load       = next != state && counted(next);
    load_val   = (next == MY || next == SY) ? 8'(YEL_CYC - 1) : 8'(ALLRED_CYC - 1);
    min_done_n = state == MG && next == MG && (min_done || t);
    enter_sg   = next == SG && state != SG;
    ped_pend_n = enter_sg ? 1'b0 : (ped_pend || ped_req);
    walk_n     = next != SG ? 1'b0 : enter_sg ? (ped_pend || ped_req) : walk;
    // holding ct high in MG after expiry parks the timer so t cannot fire again
    ct_n       = next == MG ? min_done_n : next != SG;
  end
  always_ff @(posedge tclk or negedge rst_n)
    if (!rst_n) begin
      state    <= AR_S;
      min_done <= 1'b0;
      ped_pend <= 1'b0;
      walk     <= 1'b0;
      ct       <= 1'b1;
    end else begin
      state    <= next;
      min_done <= min_done_n;
      ped_pend <= ped_pend_n;
      walk     <= walk_n;
      ct       <= ct_n;
    end
  assign main_light = state == MG ? GRN : state == MY ? YEL : RED;
  assign side_light = state == SG ? GRN : state == SY ? YEL : RED;
  assign state_o    = state;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed bench with an attached 1800-count green timer model
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;
  logic tclk = 1'b0, rst_n = 1'b0, t = 1'b0, car_side = 1'b0, ped_req = 1'b0;
  logic ct, walk;
  logic [2:0] main_light, side_light, state_o;
  int tmr = TIMER_RELOAD;
  int errors = 0, checks = 0;

  traffic_phase_ctrl #(.YEL_CYC(6), .ALLRED_CYC(4)) dut (
    .tclk(tclk), .rst_n(rst_n), .t(t), .car_side(car_side), .ped_req(ped_req),
    .ct(ct), .main_light(main_light), .side_light(side_light), .walk(walk), .state_o(state_o)
  );

  always #5 tclk = ~tclk;
  always @(posedge tclk) tmr <= ct ? TIMER_RELOAD : (tmr != 0 ? tmr - 1 : 0);
  always @(negedge tclk) t <= tmr == 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge inside state st that is cycle number pre of that state.
  task automatic phase(input string tag, input logic [2:0] st, input int pre, input int exp_len,
                       input logic [2:0] em, input logic [2:0] es, input int exp_walk);
    int len, wk;
    chk({tag, "_state"}, state_o, st);
    chk({tag, "_main"}, main_light, em);
    chk({tag, "_side"}, side_light, es);
    len = pre;
    wk = int'(walk);
    for (int i = 0; i < 10000; i++) begin
      @(negedge tclk);
      if (state_o != st) break;
      len++;
      wk += int'(walk);
    end
    chk({tag, "_len"}, len, exp_len);
    chk({tag, "_walk"}, wk, exp_walk);
  endtask

  initial begin
    int n, tp, wk;
    repeat (2) @(negedge tclk);
    chk("rst_main", main_light, RED);
    chk("rst_side", side_light, RED);
    chk("rst_ct", ct, 1);
    chk("rst_walk", walk, 0);
    chk("rst_state", state_o, AR_S);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge tclk); n++; end while (state_o != MG && n < 20);
    chk("mg_entry_cycles", n, 4);
    chk("mg_entry_ct", ct, 0);
    // MG with no demand: holds, ct parks after expiry, no further t pulses
    tp = 0;
    for (int k = 2; k <= 5000; k++) begin
      @(negedge tclk);
      if (k == 1801) chk("ct_before_t", ct, 0);
      if (k == 1802) chk("ct_after_t", ct, 1);
      if (k >= 1810) tp += int'(t);
    end
    chk("no_t_repeat", tp, 0);
    chk("mg_hold_state", state_o, MG);
    chk("mg_hold_main", main_light, GRN);
    // constant side demand: full cycle
    car_side = 1'b1;
    @(negedge tclk);
    phase("c_my", MY, 1, 6, YEL, RED, 0);
    phase("c_arm", AR_M, 1, 4, RED, RED, 0);
    phase("c_sg", SG, 1, 1801, RED, GRN, 0);
    phase("c_sy", SY, 1, 6, RED, YEL, 0);
    phase("c_ars", AR_S, 1, 4, RED, RED, 0);
    // pedestrian pulse in MG without cars
    car_side = 1'b0;
    repeat (9) @(negedge tclk);
    ped_req = 1'b1;
    @(negedge tclk);
    ped_req = 1'b0;
    phase("p_mg", MG, 11, 1801, GRN, RED, 0);
    phase("p_my", MY, 1, 6, YEL, RED, 0);
    phase("p_arm", AR_M, 1, 4, RED, RED, 0);
    phase("p_sg", SG, 1, 1801, RED, GRN, 1801);
    phase("p_sy", SY, 1, 6, RED, YEL, 0);
    phase("p_ars", AR_S, 1, 4, RED, RED, 0);
    // request was consumed: MG must now hold past minimum
    repeat (1899) @(negedge tclk);
    chk("pend_clear_state", state_o, MG);
    chk("pend_clear_ct", ct, 1);
    car_side = 1'b1;
    @(negedge tclk);
    phase("e_my", MY, 1, 6, YEL, RED, 0);
    repeat (3) @(negedge tclk);
    ped_req = 1'b1;
    @(negedge tclk);
    ped_req = 1'b0;
    chk("e_sg_entry", state_o, SG);
    chk("e_sg_walk", walk, 1);
    repeat (99) @(negedge tclk);
    ped_req = 1'b1;
    @(negedge tclk);
    ped_req = 1'b0;
    phase("e_sg", SG, 101, 1801, RED, GRN, 1701);
    phase("e_sy", SY, 1, 6, RED, YEL, 0);
    phase("e_ars", AR_S, 1, 4, RED, RED, 0);
    phase("e_mg", MG, 1, 1801, GRN, RED, 0);
    phase("e_my2", MY, 1, 6, YEL, RED, 0);
    phase("e_arm2", AR_M, 1, 4, RED, RED, 0);
    // latched request served in this SG; reset hits at cycle 900
    wk = int'(walk);
    repeat (899) @(negedge tclk) wk += int'(walk);
    chk("r_sg_walk", wk, 900);
    chk("r_sg_state", state_o, SG);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_main", main_light, RED);
    chk("r_async_side", side_light, RED);
    chk("r_async_ct", ct, 1);
    chk("r_async_walk", walk, 0);
    chk("r_async_state", state_o, AR_S);
    @(negedge tclk);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge tclk); n++; end while (state_o != MG && n < 20);
    chk("r_mg_entry_cycles", n, 4);
    chk("r_mg_main", main_light, GRN);
    chk("r_mg_ct", ct, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
